dsp_mac_pipe: RTL

- Parametrised pipelined pre-add / multiply / post-add-accumulate slice for the DSP datapath.
- Next generation of the existing fixed-width DSP slice. Adds:
  - generic operand widths;
  - optional M register;
  - a per-sample valid pipeline with bubbles;
  - synchronous accumulator clear;
  - optional saturation with a sticky overflow flag.
- Slices cascade through PCIN/PCOUT and BCOUT.

---
 rtl/dsp_mac_pipe.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/dsp_mac_pipe.sv
// Pipelined pre-add / multiply / post-add-accumulate slice with valid tracking,
// optional M register, accumulator clear and optional saturation.
module dsp_mac_pipe #(
  parameter int AW     = 18,
  parameter int BW     = 18,
  parameter int PW     = 48,
  parameter int MREG   = 1,
  parameter int SAT_EN = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             IN_VALID,
  input  logic [AW-1:0]    A,
  input  logic [BW-1:0]    B,
  input  logic [BW-1:0]    D,
  input  logic [PW-1:0]    C,
  input  logic [PW-1:0]    PCIN,
  input  logic             CARRYIN,
  input  logic [4:0]       OPMODE,
  input  logic             ACC_CLR,
  output logic [AW+BW-1:0] M,
  output logic [PW-1:0]    P,
  output logic [PW-1:0]    PCOUT,
  output logic [BW-1:0]    BCOUT,
  output logic             CARRYOUT,
  output logic             OVF,
  output logic             OUT_VALID
);

  localparam int   MW     = AW + BW;
  localparam logic SAT_ON = (SAT_EN != 0);

  // Stage 1: raw input capture
  logic [AW-1:0] a1_q;
  logic [BW-1:0] b1_q, d1_q;
  logic [PW-1:0] c1_q;
  logic [4:0]    op1_q;
  logic          cin1_q, clr1_q, v1_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a1_q   <= '0;
      b1_q   <= '0;
      d1_q   <= '0;
      c1_q   <= '0;
      op1_q  <= 5'b0_0000;
      cin1_q <= 1'b0;
      clr1_q <= 1'b0;
      v1_q   <= 1'b0;
    end else if (CE) begin
      a1_q   <= A;
      b1_q   <= B;
      d1_q   <= D;
      c1_q   <= C;
      op1_q  <= OPMODE;
      cin1_q <= CARRYIN;
      clr1_q <= ACC_CLR;
      v1_q   <= IN_VALID;
    end
  end

  // Stage 2: pre-adder result plus the fields still needed downstream
  logic [BW-1:0] pre2_d, pre2_q;
  logic [AW-1:0] a2_q;
  logic [PW-1:0] c2_q;
  logic [1:0]    zsel2_q;
  logic          sub2_q, cin2_q, clr2_q, v2_q;

  always_comb begin
    pre2_d = b1_q;
    if (op1_q[3]) begin
      if (op1_q[2]) begin
        pre2_d = d1_q - b1_q;
      end else begin
        pre2_d = d1_q + b1_q;
      end
    end else begin
      pre2_d = b1_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre2_q  <= '0;
      a2_q    <= '0;
      c2_q    <= '0;
      zsel2_q <= 2'b00;
      sub2_q  <= 1'b0;
      cin2_q  <= 1'b0;
      clr2_q  <= 1'b0;
      v2_q    <= 1'b0;
    end else if (CE) begin
      pre2_q  <= pre2_d;
      a2_q    <= a1_q;
      c2_q    <= c1_q;
      zsel2_q <= op1_q[1:0];
      sub2_q  <= op1_q[4];
      cin2_q  <= cin1_q;
      clr2_q  <= clr1_q;
      v2_q    <= v1_q;
    end
  end

  logic [MW-1:0] prod_s;
  assign prod_s = {{BW{1'b0}}, a2_q} * {{AW{1'b0}}, pre2_q};

  // Stage 3 outputs: either the M register bank or a straight pass-through
  logic [MW-1:0] m3_s;
  logic [PW-1:0] c3_s;
  logic [1:0]    zsel3_s;
  logic          sub3_s, cin3_s, clr3_s, v3_s;

  if (MREG != 0) begin : g_mreg
    logic [MW-1:0] m3_q;
    logic [PW-1:0] c3_q;
    logic [1:0]    zsel3_q;
    logic          sub3_q, cin3_q, clr3_q, v3_q;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        m3_q    <= '0;
        c3_q    <= '0;
        zsel3_q <= 2'b00;
        sub3_q  <= 1'b0;
        cin3_q  <= 1'b0;
        clr3_q  <= 1'b0;
        v3_q    <= 1'b0;
      end else if (CE) begin
        m3_q    <= prod_s;
        c3_q    <= c2_q;
        zsel3_q <= zsel2_q;
        sub3_q  <= sub2_q;
        cin3_q  <= cin2_q;
        clr3_q  <= clr2_q;
        v3_q    <= v2_q;
      end
    end

    assign m3_s    = m3_q;
    assign c3_s    = c3_q;
    assign zsel3_s = zsel3_q;
    assign sub3_s  = sub3_q;
    assign cin3_s  = cin3_q;
    assign clr3_s  = clr3_q;
    assign v3_s    = v3_q;
  end else begin : g_nomreg
    assign m3_s    = prod_s;
    assign c3_s    = c2_q;
    assign zsel3_s = zsel2_q;
    assign sub3_s  = sub2_q;
    assign cin3_s  = cin2_q;
    assign clr3_s  = clr2_q;
    assign v3_s    = v2_q;
  end

  // Post-adder: bit PW of the PW+1-bit result is carry (add) or borrow (subtract)
  logic [PW-1:0] p_q, p_d, z_s;
  logic [PW:0]   addend_s, sum_s;
  logic          co_q, ovf_q, ovf_d, ovf_now_s, ov_q;

  always_comb begin
    z_s = '0;
    case (zsel3_s)
      2'b00:   z_s = '0;
      2'b01:   z_s = p_q;
      2'b10:   z_s = c3_s;
      2'b11:   z_s = PCIN;
      default: z_s = '0;
    endcase
    if (clr3_s) begin
      z_s = '0;
    end else begin
      z_s = z_s;
    end
    addend_s = {{(PW + 1 - MW){1'b0}}, m3_s} + {{PW{1'b0}}, cin3_s};
    if (sub3_s) begin
      sum_s = {1'b0, z_s} - addend_s;
    end else begin
      sum_s = {1'b0, z_s} + addend_s;
    end
    ovf_now_s = SAT_ON & sum_s[PW];
    if (ovf_now_s) begin
      p_d = sub3_s ? {PW{1'b0}} : {PW{1'b1}};
    end else begin
      p_d = sum_s[PW-1:0];
    end
    if (clr3_s) begin
      ovf_d = ovf_now_s;
    end else begin
      ovf_d = ovf_q | ovf_now_s;
    end
  end

  // Stage 4: result registers update only for valid samples; OUT_VALID follows every enabled edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p_q   <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
      ov_q  <= 1'b0;
    end else if (CE) begin
      ov_q <= v3_s;
      if (v3_s) begin
        p_q   <= p_d;
        co_q  <= sum_s[PW];
        ovf_q <= ovf_d;
      end
    end
  end

  assign M         = m3_s;
  assign P         = p_q;
  assign PCOUT     = p_q;
  assign BCOUT     = pre2_q;
  assign CARRYOUT  = co_q;
  assign OVF       = ovf_q;
  assign OUT_VALID = ov_q;

endmodule
